// File: rtl/mem_access_ctrl.sv
// Multicycle controller between the control FSM and the word-addressed main memory.
// Optional read/write completion counters are built when MEM_ACCESS_STATS_EN is defined.
module mem_access_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic signed [DATA_W-1:0] req_wdata,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] rdata,
    output logic                     mem_read_enable,
    output logic                     mem_write_enable,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic signed [DATA_W-1:0] mem_write_data,
    input  logic signed [DATA_W-1:0] mem_data_in
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                     state;
    state_t                     state_nxt;
    logic [3:0]                 cnt;
    logic                       last;
    logic                       we_p0;
    logic [ADDR_W-1:0]          addr_p0;
    logic signed [DATA_W-1:0]   wdata_p0;
    logic signed [DATA_W-1:0]   rdata_p1;

    assign last           = (cnt == 4'd0);
    assign mem_addr       = addr_p0;
    assign mem_write_data = wdata_p0;
    assign rdata          = rdata_p1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        busy             = 1'b0;
        done             = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nxt = ACCESS;
            end
            ACCESS: begin
                busy             = 1'b1;
                mem_read_enable  = ~we_p0;
                // A single write strobe in the last cycle gives exactly one commit edge.
                mem_write_enable = we_p0 & last;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: request capture and wait counter; p1: memory data register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            we_p0    <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
            rdata_p1 <= '0;
        end else begin
            if (state == IDLE && req) begin
                we_p0    <= req_we;
                addr_p0  <= req_addr;
                wdata_p0 <= req_wdata;
                cnt      <= WAIT_INIT;
            end else if (state == ACCESS && !last) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS && last && !we_p0) rdata_p1 <= mem_data_in;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == DONE) begin
            if (we_p0) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: four instances (WAIT_CYCLES 0..3), each with its own memory,
// checked against an address-map reference model and latency rules.
module tb_mem_access_ctrl;

    localparam int NI = 4;

    logic                   clk;
    logic [NI-1:0]          rst;
    logic [NI-1:0]          req;
    logic [NI-1:0]          req_we;
    logic [15:0]            req_addr       [NI];
    logic signed [15:0]     req_wdata      [NI];
    logic [NI-1:0]          busy;
    logic [NI-1:0]          done;
    logic signed [15:0]     rdata          [NI];
    logic [NI-1:0]          mem_re;
    logic [NI-1:0]          mem_we;
    logic [15:0]            mem_addr       [NI];
    logic signed [15:0]     mem_write_data [NI];
    logic signed [15:0]     mem_data_in    [NI];
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0]            rd_count       [NI];
    logic [15:0]            wr_count       [NI];
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] ref_mem [int];
    logic [15:0] last_rd [NI];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] model_rd(input int k, input logic [15:0] a);
        int key;
        key = k * 65536 + int'(a);
        if (ref_mem.exists(key)) return ref_mem[key];
        return init_val(a);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [15:0] mem [65536];
        initial for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        always @(posedge clk) if (mem_we[g]) mem[mem_addr[g]] = mem_write_data[g];
        assign mem_data_in[g] = mem[mem_addr[g]];

        mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(g)) u_dut (
            .clk              (clk),
            .rst              (rst[g]),
            .req              (req[g]),
            .req_we           (req_we[g]),
            .req_addr         (req_addr[g]),
            .req_wdata        (req_wdata[g]),
            .busy             (busy[g]),
            .done             (done[g]),
            .rdata            (rdata[g]),
            .mem_read_enable  (mem_re[g]),
            .mem_write_enable (mem_we[g]),
            .mem_addr         (mem_addr[g]),
            .mem_write_data   (mem_write_data[g]),
            .mem_data_in      (mem_data_in[g])
`ifdef MEM_ACCESS_STATS_EN
            ,
            .rd_count         (rd_count[g]),
            .wr_count         (wr_count[g])
`endif
        );
    end

    // One request on instance k, observed cycle by cycle (cycle 0 = req cycle).
    task automatic run_req(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output int n_re, output int n_we, output int we_cyc,
                           output int bad, output logic [15:0] rd_at_done);
        lat = -1; n_re = 0; n_we = 0; we_cyc = -1; bad = 0; rd_at_done = 'x;
        @(negedge clk);
        req[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d;
        @(posedge clk);
        #1 req[k] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_re[k]) n_re++;
            if (mem_we[k]) begin n_we++; we_cyc = c; end
            if ((mem_re[k] || mem_we[k]) &&
                (mem_addr[k] !== a || (mem_we[k] && mem_write_data[k] !== d))) bad++;
            if (done[k]) begin lat = c; rd_at_done = rdata[k]; break; end
        end
        if (we) ref_mem[k * 65536 + int'(a)] = d;
        else    last_rd[k] = model_rd(k, a);
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req[k] = 1'b1; req_we[k] = 1'b1;
            req_addr[k] = 16'hFFFF; req_wdata[k] = 16'sh7FFF;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({busy[k], done[k], mem_re[k], mem_we[k]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got busy/done/re/we=%b expected 0000", k,
                         {busy[k], done[k], mem_re[k], mem_we[k]});
            end
            checks++;
            if ({rdata[k], mem_addr[k], mem_write_data[k]} !== 48'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got rdata=%h addr=%h wdata=%h expected 0", k,
                         rdata[k], mem_addr[k], mem_write_data[k]);
            end
            req[k] = 1'b0; rst[k] = 1'b0; last_rd[k] = 16'h0;
        end
    endtask

    task automatic test_write_read();
        int lat, n_re, n_we, we_cyc, bad;
        logic [15:0] rd;
        run_req(1, 1'b1, 16'h0010, 16'h8001, lat, n_re, n_we, we_cyc, bad, rd);
        checks++;
        if (lat != 3 || n_we != 1 || we_cyc != 2 || n_re != 0 || bad != 0) begin
            errors++;
            $display("FAIL wr_timing: got lat=%0d n_we=%0d we_cyc=%0d n_re=%0d bad=%0d expected 3 1 2 0 0",
                     lat, n_we, we_cyc, n_re, bad);
        end
        checks++;
        if (rd !== 16'h0) begin
            errors++;
            $display("FAIL wr_rdata_hold: got %h expected 0000", rd);
        end
        run_req(1, 1'b0, 16'h0010, 16'h0, lat, n_re, n_we, we_cyc, bad, rd);
        checks++;
        if (lat != 3 || n_re != 2 || n_we != 0 || bad != 0) begin
            errors++;
            $display("FAIL rd_timing: got lat=%0d n_re=%0d n_we=%0d bad=%0d expected 3 2 0 0",
                     lat, n_re, n_we, bad);
        end
        checks++;
        if (rdata[1] !== -16'sd32767) begin
            errors++;
            $display("FAIL rd_value: got %0d expected -32767", rdata[1]);
        end
    endtask

    task automatic test_random();
        int lat, n_re, n_we, we_cyc, bad, n;
        logic [15:0] rd, a, d;
        logic we;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 16; i++) begin
                we = 1'($urandom_range(0, 1));
                a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15) + 16'h0100);
                d  = 16'($urandom);
                run_req(k, we, a, d, lat, n_re, n_we, we_cyc, bad, rd);
                checks++;
                if (lat != k + 2) begin
                    errors++;
                    $display("FAIL rand_lat[%0d.%0d]: got %0d expected %0d", k, i, lat, k + 2);
                end
                n = we ? 0 : k + 1;
                checks++;
                if (n_re != n || n_we != int'(we) || (we && we_cyc != k + 1) || bad != 0) begin
                    errors++;
                    $display("FAIL rand_strobe[%0d.%0d]: got re=%0d we=%0d we_cyc=%0d bad=%0d expected re=%0d we=%0d",
                             k, i, n_re, n_we, we_cyc, bad, n, we);
                end
                checks++;
                if (rd !== last_rd[k]) begin
                    errors++;
                    $display("FAIL rand_rdata[%0d.%0d]: got %h expected %h", k, i, rd, last_rd[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones, done_c1, done_c2, idle_busy;
        logic [15:0] rd1, rd2;
        dones = 0; done_c1 = -1; done_c2 = -1; idle_busy = 1; rd1 = 'x; rd2 = 'x;
        @(negedge clk);
        req[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 16'h0001;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4) idle_busy = int'(busy[1]);
            if (done[1]) begin
                dones++;
                if (dones == 1) begin done_c1 = c; rd1 = rdata[1]; req_addr[1] = 16'h0002; end
                else begin done_c2 = c; rd2 = rdata[1]; req[1] = 1'b0; end
            end
        end
        checks++;
        if (dones != 2 || done_c1 != 3 || done_c2 != 7 || idle_busy != 0) begin
            errors++;
            $display("FAIL b2b_timing: got dones=%0d at %0d,%0d busy_c4=%0d expected 2 at 3,7 busy 0",
                     dones, done_c1, done_c2, idle_busy);
        end
        checks++;
        if (rd1 !== model_rd(1, 16'h0001) || rd2 !== model_rd(1, 16'h0002)) begin
            errors++;
            $display("FAIL b2b_rdata: got %h,%h expected %h,%h", rd1, rd2,
                     model_rd(1, 16'h0001), model_rd(1, 16'h0002));
        end
        last_rd[1] = model_rd(1, 16'h0002);
    endtask

    task automatic test_ignored_req();
        int dones, n_we, done_c;
        dones = 0; n_we = 0; done_c = -1;
        @(negedge clk);
        req[3] = 1'b1; req_we[3] = 1'b0; req_addr[3] = 16'h0005;
        @(posedge clk);
        #1 req[3] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we[3]) n_we++;
            if (done[3]) begin dones++; done_c = c; end
            if (c == 2) begin
                req[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = 16'h0006; req_wdata[3] = 16'sh1111;
            end
            if (c == 3) req[3] = 1'b0;
        end
        checks++;
        if (dones != 1 || done_c != 5 || n_we != 0) begin
            errors++;
            $display("FAIL ignored_req: got dones=%0d done_c=%0d writes=%0d expected 1 5 0",
                     dones, done_c, n_we);
        end
        checks++;
        if (rdata[3] !== model_rd(3, 16'h0005)) begin
            errors++;
            $display("FAIL ignored_rdata: got %h expected %h", rdata[3], model_rd(3, 16'h0005));
        end
        last_rd[3] = model_rd(3, 16'h0005);
    endtask

    task automatic test_wait_extremes();
        int lat, n_re, n_we, we_cyc, bad;
        logic [15:0] rd;
        for (int k = 0; k < NI; k += 3) begin
            run_req(k, 1'b1, 16'hFFFF, 16'h7FFF, lat, n_re, n_we, we_cyc, bad, rd);
            checks++;
            if (n_we != 1 || we_cyc != k + 1 || bad != 0) begin
                errors++;
                $display("FAIL edge_write[%0d]: got n_we=%0d we_cyc=%0d bad=%0d expected 1 %0d 0",
                         k, n_we, we_cyc, bad, k + 1);
            end
            run_req(k, 1'b0, 16'hFFFF, 16'h0, lat, n_re, n_we, we_cyc, bad, rd);
            checks++;
            if (lat != k + 2 || n_re != k + 1) begin
                errors++;
                $display("FAIL edge_rd_lat[%0d]: got lat=%0d n_re=%0d expected %0d %0d",
                         k, lat, n_re, k + 2, k + 1);
            end
            checks++;
            if (rd !== 16'h7FFF || bad != 0) begin
                errors++;
                $display("FAIL edge_rd_value[%0d]: got %h bad=%0d expected 7fff", k, rd, bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen_we, dones, lat, n_re, n_we, we_cyc, bad;
        logic [15:0] rd;
        seen_we = 0; dones = 0;
        @(negedge clk);
        req[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 16'h0040; req_wdata[2] = 16'sh1234;
        @(posedge clk);
        #1 req[2] = 1'b0;
        @(negedge clk);
        if (mem_we[2]) seen_we++;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        checks++;
        if (busy[2] !== 1'b0 || done[2] !== 1'b0 || rdata[2] !== 16'sh0) begin
            errors++;
            $display("FAIL mid_reset_state: got busy=%b done=%b rdata=%h expected 0 0 0000",
                     busy[2], done[2], rdata[2]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_we[2]) seen_we++;
            if (done[2]) dones++;
        end
        checks++;
        if (seen_we != 0 || dones != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got writes=%0d dones=%0d expected 0 0", seen_we, dones);
        end
        last_rd[2] = 16'h0;
        run_req(2, 1'b0, 16'h0040, 16'h0, lat, n_re, n_we, we_cyc, bad, rd);
        checks++;
        if (rd !== model_rd(2, 16'h0040) || lat != 4) begin
            errors++;
            $display("FAIL mid_reset_old: got %h lat=%0d expected %h lat=4", rd, lat,
                     model_rd(2, 16'h0040));
        end
    endtask

`ifdef MEM_ACCESS_STATS_EN
    task automatic test_stats();
        int lat, n_re, n_we, we_cyc, bad;
        logic [15:0] rd;
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        last_rd[1] = 16'h0;
        for (int i = 0; i < 3; i++) run_req(1, 1'b0, 16'(16'h0200 + i), 16'h0, lat, n_re, n_we, we_cyc, bad, rd);
        for (int i = 0; i < 2; i++) run_req(1, 1'b1, 16'(16'h0300 + i), 16'(i), lat, n_re, n_we, we_cyc, bad, rd);
        @(negedge clk);
        checks++;
        if (rd_count[1] !== 16'd3 || wr_count[1] !== 16'd2) begin
            errors++;
            $display("FAIL stats_counts: got rd=%0d wr=%0d expected 3 2", rd_count[1], wr_count[1]);
        end
    endtask
`endif

    initial begin
        rst = '0; req = '0; req_we = '0;
        for (int k = 0; k < NI; k++) begin
            req_addr[k] = '0; req_wdata[k] = '0; last_rd[k] = '0;
        end
        test_reset();
        test_write_read();
        test_random();
        test_back_to_back();
        test_ignored_req();
        test_wait_extremes();
        test_reset_mid();
`ifdef MEM_ACCESS_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
